fetch_ctrl: RTL

FETCH_CTRL -- requirements
Module: fetch_ctrl

---
 rtl/fetch_defs_pkg.sv | 19 +
 rtl/inst_skid_buf.sv | 65 ++++++
 rtl/fetch_ctrl.sv | 101 ++++++++++
 3 files changed

// File: rtl/fetch_defs_pkg.sv
// Shared definitions for the instruction fetch controller: state encodings,
// widths, PC increment and the default reset PC.
package fetch_defs;
    localparam int          INST_W       = 32;
    localparam logic [31:0] PC_INC       = 32'd4;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        STALL = 2'd2,
        FLUSH = 2'd3
    } fetch_state_t;

    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic [INST_W-1:0] pc;
    } fetch_ent_t;
endpackage

// File: rtl/inst_skid_buf.sv
// Output register plus one-entry skid for fetched instructions.
// skid_vld_nxt is the skid occupancy after the coming edge, used by the FSM.
module inst_skid_buf
    import fetch_defs::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       flush,
    input  logic       push,
    input  fetch_ent_t push_ent,
    input  logic       stall,
    output logic       out_vld,
    output fetch_ent_t out_ent,
    output logic       skid_vld_nxt
);
    logic       skid_vld;
    fetch_ent_t skid_ent;
    logic       deliver;
    logic       out_vld_nxt;
    logic       load_out;
    logic       load_skid;
    logic       move;

    always_comb begin
        deliver      = out_vld & ~stall;
        out_vld_nxt  = out_vld;
        skid_vld_nxt = skid_vld;
        load_out     = 1'b0;
        load_skid    = 1'b0;
        move         = 1'b0;
        if (flush) begin
            out_vld_nxt  = 1'b0;
            skid_vld_nxt = 1'b0;
        end else if (deliver || !out_vld) begin
            // Output slot frees up: skid drains first, new data backfills.
            if (skid_vld) begin
                move         = 1'b1;
                out_vld_nxt  = 1'b1;
                skid_vld_nxt = push;
                load_skid    = push;
            end else begin
                out_vld_nxt = push;
                load_out    = push;
            end
        end else if (push) begin
            skid_vld_nxt = 1'b1;
            load_skid    = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_vld  <= 1'b0;
            skid_vld <= 1'b0;
            out_ent  <= '0;
            skid_ent <= '0;
        end else begin
            out_vld  <= out_vld_nxt;
            skid_vld <= skid_vld_nxt;
            if (move)      out_ent  <= skid_ent;
            if (load_out)  out_ent  <= push_ent;
            if (load_skid) skid_ent <= push_ent;
        end
    end
endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: FSM and fetch PC driving a single-outstanding
// memory read, with redirect handling and a skid-buffered output.
module fetch_ctrl
    import fetch_defs::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_i,
    input  logic              branch_flag_i,
    input  logic [31:0]       branch_target_i,
    output logic              mem_req_o,
    output logic [31:0]       mem_addr_o,
    input  logic              mem_ack_i,
    input  logic [INST_W-1:0] mem_rdata_i,
    output logic              inst_valid_o,
    output logic [INST_W-1:0] inst_o,
    output logic [31:0]       pc_o
);
    fetch_state_t state, nxt;
    logic [31:0]  pc, pc_nxt;
    logic [31:0]  pend, pend_nxt;
    logic         push;
    logic         skid_vld_nxt;
    fetch_ent_t   push_ent, out_ent;

    assign mem_req_o  = (state == REQ) || (state == FLUSH);
    assign mem_addr_o = pc;
    assign push       = (state == REQ) && mem_ack_i && !branch_flag_i;
    assign push_ent   = '{inst: mem_rdata_i, pc: pc};

    always_comb begin
        nxt      = state;
        pc_nxt   = pc;
        pend_nxt = pend;
        case (state)
            IDLE: begin
                nxt = REQ;
                if (branch_flag_i) pc_nxt = branch_target_i;
            end
            REQ: begin
                if (branch_flag_i) begin
                    // Without an ack the old request must still complete.
                    if (mem_ack_i) pc_nxt = branch_target_i;
                    else begin
                        pend_nxt = branch_target_i;
                        nxt      = FLUSH;
                    end
                end else if (mem_ack_i) begin
                    pc_nxt = pc + PC_INC;
                    nxt    = skid_vld_nxt ? STALL : REQ;
                end
            end
            STALL: begin
                if (branch_flag_i) begin
                    pc_nxt = branch_target_i;
                    nxt    = REQ;
                end else if (!skid_vld_nxt) begin
                    nxt = REQ;
                end
            end
            FLUSH: begin
                if (mem_ack_i) begin
                    pc_nxt = branch_flag_i ? branch_target_i : pend;
                    nxt    = REQ;
                end else if (branch_flag_i) begin
                    pend_nxt = branch_target_i;
                end
            end
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            pc    <= RESET_PC;
            pend  <= '0;
        end else begin
            state <= nxt;
            pc    <= pc_nxt;
            pend  <= pend_nxt;
        end
    end

    inst_skid_buf u_buf (
        .clk          (clk),
        .rst          (rst),
        .flush        (branch_flag_i),
        .push         (push),
        .push_ent     (push_ent),
        .stall        (stall_i),
        .out_vld      (inst_valid_o),
        .out_ent      (out_ent),
        .skid_vld_nxt (skid_vld_nxt)
    );

    assign inst_o = out_ent.inst;
    assign pc_o   = out_ent.pc;
endmodule
